// File: rtl/ro_bus_capture.sv
// rtl/ro_bus_capture.sv - gray-sequence tracking readout bus capture with output FIFO.
// Optional RO_SPARSE_EN: drop all-zero samples before they reach the FIFO.
module ro_bus_capture #(
    parameter int NCH   = 17,
    parameter int IDXW  = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     en,
    input  logic                     bus_pol,
    input  logic                     bus_pol_eve,
    output logic [IDXW+1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int RW = IDXW + 2;
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(DEPTH);

    logic [NCH-1:0]  tick_q, tick_d, tick_inc;
    logic [IDXW-1:0] idx_q, idx_d, cur_idx;
    logic            arm_q, arm_d;
    logic [RW-1:0]   mem_q [DEPTH];
    logic [RW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            sample, push, pop, full, accept;
    logic [RW-1:0]   rec;

    assign tick_inc = tick_q + 1'b1;

    // Lowest set bit of the next tick is the gray bit that toggles; wrap to 0 toggles the MSB.
    always_comb begin
        cur_idx = IDXW'(NCH - 1);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (tick_inc[i]) cur_idx = IDXW'(i);
        end
    end

    always_comb begin
        tick_d     = tick_q;
        idx_d      = idx_q;
        arm_d      = 1'b0;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (en) begin
            tick_d = tick_inc;
            idx_d  = cur_idx;
            arm_d  = 1'b1;
        end

        // The bus seen now belongs to the channel that toggled on the previous edge.
        sample = en & arm_q;
        rec    = {idx_q, bus_pol_eve, bus_pol};
`ifdef RO_SPARSE_EN
        push   = sample & (bus_pol | bus_pol_eve);
`else
        push   = sample;
`endif
        full   = (count_q == FULL_LVL);
        pop    = (count_q != '0) & out_ready;
        accept = push & (~full | pop);

        if (accept) begin
            mem_d[wr_ptr_q] = rec;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push & full & ~pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tick_q     <= '0;
            idx_q      <= '0;
            arm_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            arm_q      <= arm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign overflow  = overflow_q;
    assign level     = count_q;

endmodule
